lpf_frame_ctrl: RTL and testbench
=================================

# lpf_frame_ctrl

Frame sequencer for the three-channel RGB565 Gaussian low-pass filter. It gates the filter's `i_enable`, issues `i_flush` at end of frame and on abort, and counts pixels consumed from the input FIFO and delivered from the output buffer. It detects frame completion, stalls and lane-desync errors, and reports frame status to the capture/display control logic.

## Interface
Parameters:
- `LINE_LENGTH`, 480: pixels per line.
- `LINE_COUNT`, 480: lines per frame. `FRAME_PIXELS = LINE_LENGTH*LINE_COUNT`.
- `FLUSH_CYCLES`, 2: cycles `o_flush` is held high, range 1..15.
- `TIMEOUT`, 65535: maximum idle-progress cycles in RUN or DRAIN before the stall error.

Ports:
- `i_clk`  in  1  single clock.
- `i_rstn`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  start-frame request, sampled in IDLE only.
- `i_abort`  in  1  abort the current frame.
- `i_clear`  in  1  leave ERROR.
- `i_lpf_rd`  in  1  filter input-FIFO read strobe; one pixel consumed.
- `i_obuf_rd`  in  1  downstream read of filter output buffer; one pixel delivered.
- `i_lpf_error`  in  1  filter lane-desync flag.
- `o_enable`  out  1  drives filter `i_enable`.
- `o_flush`  out  1  drives filter `i_flush`.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_done`  out  1  one-cycle frame-complete pulse.
- `o_err`  out  1  high while in ERROR.
- `o_err_code`  out  2  last error cause: 01 = lane desync, 10 = stall timeout, 11 = input overrun.
- `o_in_count`  out  CW  pixels consumed this frame; `CW = $clog2(FRAME_PIXELS+1)`.
- `o_out_count`  out  CW  pixels delivered this frame.

## Operation
- States: IDLE, RUN, FLUSH, DRAIN, DONE, ABORT, ERROR. All outputs are registered, decoded from the state and counters.
- **IDLE**
  - Outputs: `o_enable`=0, `o_flush`=0.
  - `i_start` clears both counters and the timeout counter, then moves to RUN.
- **RUN**
  - Outputs: `o_enable`=1.
  - `i_lpf_rd` increments `in_count`; `i_obuf_rd` increments `out_count`.
  - The `i_lpf_rd` that makes `in_count`==FRAME_PIXELS moves to FLUSH.
- **FLUSH**
  - Outputs: `o_enable`=1, `o_flush`=1 for exactly FLUSH_CYCLES cycles, then DRAIN.
  - `out_count` keeps counting.
- **DRAIN**
  - Outputs: `o_enable`=1.
  - The `i_obuf_rd` that makes `out_count`==FRAME_PIXELS moves to DONE.
  - If `out_count` already equals FRAME_PIXELS on entry, go straight to DONE.
- **DONE**
  - Outputs: `o_done`=1 for one cycle, `o_enable`=0. Next state is IDLE.
  - Counters hold their final values until the next `i_start`.
- **ABORT**
  - Entered from RUN, FLUSH or DRAIN on `i_abort`.
  - Outputs: `o_enable`=0, `o_flush`=1 for FLUSH_CYCLES cycles, then IDLE. No `o_done`.
- **ERROR**
  - Outputs: `o_enable`=0, `o_flush`=1 held, `o_err`=1.
  - `i_clear` moves to IDLE and clears `o_err`; `o_err_code` is retained.
- Error entry, from RUN, FLUSH or DRAIN:
  - `i_lpf_error` → code 01.
  - `i_lpf_rd` in FLUSH or DRAIN → code 11 (overrun).
  - Timeout counter reaching TIMEOUT → code 10. The counter runs in RUN and DRAIN only and resets on any `i_lpf_rd` or `i_obuf_rd`.
- Priority within one cycle: error > `i_abort` > normal transition. Lane desync ranks above overrun, which ranks above timeout.
- Counters saturate at FRAME_PIXELS; `i_obuf_rd` beyond that is ignored. Strobes outside RUN/FLUSH/DRAIN are ignored.

## Timing
- Reset values:
  - state = IDLE.
  - `o_enable`, `o_flush`, `o_busy`, `o_done`, `o_err` = 0.
  - `o_err_code` = 00.
  - both counts = 0.
- Reset is effective immediately, mid-frame included. No flush is generated by reset.
- `i_start` sampled at edge N gives `o_enable`=1 and `o_busy`=1 from cycle N+1.
- A strobe at edge N is reflected in its count at N+1.
- The last input read at edge N gives `o_flush`=1 for cycles N+1..N+FLUSH_CYCLES.
- The final output read at edge M (M ≥ end of flush) gives `o_done`=1 in cycle M+1 and `o_busy`=0 in cycle M+2.
- `i_start` and `i_abort` together in IDLE: start wins, because abort is ignored in IDLE.

## Test plan
With LINE_LENGTH=4, LINE_COUNT=2, FLUSH_CYCLES=2, TIMEOUT=16:
- **Normal frame:** `i_start`, then 8 `i_lpf_rd` with interleaved `i_obuf_rd`, then the remaining `i_obuf_rd` → `o_flush` high 2 cycles after the 8th `i_lpf_rd`, one `o_done` pulse after the 8th `i_obuf_rd`, counts 8/8.
- **Early drain:** all 8 `i_obuf_rd` occur before FLUSH ends → DRAIN exits immediately, `o_done` one cycle after DRAIN entry.
- **Abort:** `i_abort` after 3 reads → `o_enable`=0, `o_flush` high 2 cycles, back to IDLE, no `o_done`, `o_in_count`=3.
- **Stall:** 16 cycles with no strobe in RUN → `o_err`=1, `o_err_code`=10, `o_flush` held. `i_clear` → IDLE.
- **Overrun and priority:** `i_lpf_rd` during FLUSH → code 11. `i_lpf_error` together with `i_abort` → ERROR with code 01.
- **Reset mid-DRAIN:** assert `i_rstn`=0 in DRAIN → all outputs 0 asynchronously. A subsequent `i_start` runs a full normal frame.

Source files
------------

// File: rtl/lpf_frame_ctrl.sv
// Frame sequencer for the RGB565 Gaussian low-pass filter: gates the filter
// enable, issues flushes at end of frame and on abort, counts pixels in and
// out, and reports completion, stall and desync/overrun errors.
module lpf_frame_ctrl #(
  parameter  int LINE_LENGTH  = 480,
  parameter  int LINE_COUNT   = 480,
  parameter  int FLUSH_CYCLES = 2,
  parameter  int TIMEOUT      = 65535,
  localparam int FRAME_PIXELS = LINE_LENGTH * LINE_COUNT,
  localparam int CW           = $clog2(FRAME_PIXELS + 1)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_clear,
  input  logic          i_lpf_rd,
  input  logic          i_obuf_rd,
  input  logic          i_lpf_error,
  output logic          o_enable,
  output logic          o_flush,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [1:0]    o_err_code,
  output logic [CW-1:0] o_in_count,
  output logic [CW-1:0] o_out_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] FP_FULL  = CW'(FRAME_PIXELS);
  localparam logic [CW-1:0] FP_LAST  = CW'(FRAME_PIXELS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    FC_LAST  = 4'(FLUSH_CYCLES - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DESYNC  = 2'b01;
  localparam logic [1:0] ERR_STALL   = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_ABORT = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] in_q, in_d;
  logic [CW-1:0] out_q, out_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    fc_q, fc_d;
  logic [1:0]    code_q, code_d;

  logic          enable_q, flush_q, busy_q, done_q, err_q;

  logic          active;
  logic          timed;
  logic          strobe;
  logic          in_sat, out_sat;
  logic          in_fin, out_fin;
  logic [1:0]    err_cause;

  assign active  = (state_q == S_RUN) || (state_q == S_FLUSH) || (state_q == S_DRAIN);
  assign timed   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign strobe  = i_lpf_rd || i_obuf_rd;
  assign in_sat  = (in_q == FP_FULL);
  assign out_sat = (out_q == FP_FULL);
  assign in_fin  = i_lpf_rd && (in_q == FP_LAST);
  assign out_fin = i_obuf_rd && (out_q == FP_LAST);

  // Error cause for this cycle, ranked desync > overrun > stall timeout
  always_comb begin
    err_cause = ERR_NONE;
    if (active) begin
      if (i_lpf_error) begin
        err_cause = ERR_DESYNC;
      end else if (i_lpf_rd && (state_q != S_RUN)) begin
        err_cause = ERR_OVERRUN;
      end else if (timed && !strobe && (tmo_q == TMO_LAST)) begin
        err_cause = ERR_STALL;
      end
    end
  end

  // Next-state, counter and error-code logic
  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    out_d   = out_q;
    tmo_d   = tmo_q;
    fc_d    = fc_q;
    code_d  = code_q;

    // Pixel counters run only while a frame is in flight and saturate at a full frame
    if (active) begin
      if (i_lpf_rd && !in_sat) begin
        in_d = in_q + CW'(1);
      end
      if (i_obuf_rd && !out_sat) begin
        out_d = out_q + CW'(1);
      end
    end

    // Idle-progress timer: counts in RUN/DRAIN, any strobe restarts it
    if (timed) begin
      tmo_d = strobe ? '0 : tmo_q + TW'(1);
    end else begin
      tmo_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          in_d    = '0;
          out_d   = '0;
          tmo_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN, S_FLUSH, S_DRAIN: begin
        if (err_cause != ERR_NONE) begin
          code_d  = err_cause;
          state_d = S_ERROR;
        end else if (i_abort) begin
          fc_d    = '0;
          state_d = S_ABORT;
        end else begin
          case (state_q)
            S_RUN: begin
              if (in_fin) begin
                fc_d    = '0;
                state_d = S_FLUSH;
              end
            end
            S_FLUSH: begin
              if (fc_q == FC_LAST) begin
                state_d = S_DRAIN;
              end else begin
                fc_d = fc_q + 4'd1;
              end
            end
            default: begin
              // DRAIN: a frame already fully delivered leaves on the first cycle
              if (out_sat || out_fin) begin
                state_d = S_DONE;
              end
            end
          endcase
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ABORT: begin
        if (fc_q == FC_LAST) begin
          state_d = S_IDLE;
        end else begin
          fc_d = fc_q + 4'd1;
        end
      end
      S_ERROR: begin
        if (i_clear) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and error code
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      in_q    <= '0;
      out_q   <= '0;
      tmo_q   <= '0;
      fc_q    <= '0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      out_q   <= out_d;
      tmo_q   <= tmo_d;
      fc_q    <= fc_d;
      code_q  <= code_d;
    end
  end

  // Registered status outputs decoded from the upcoming state
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      enable_q <= 1'b0;
      flush_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      enable_q <= (state_d == S_RUN) || (state_d == S_FLUSH) || (state_d == S_DRAIN);
      flush_q  <= (state_d == S_FLUSH) || (state_d == S_ABORT) || (state_d == S_ERROR);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      err_q    <= (state_d == S_ERROR);
    end
  end

  assign o_enable    = enable_q;
  assign o_flush     = flush_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_err_code  = code_q;
  assign o_in_count  = in_q;
  assign o_out_count = out_q;

endmodule

// File: tb/tb_lpf_frame_ctrl.sv
// Self-checking bench for lpf_frame_ctrl with an 8-pixel frame (4x2),
// two flush cycles and a 16-cycle stall timeout.
module tb_lpf_frame_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start, abort, clear, lpf_rd, obuf_rd, lpf_err;
  logic       en, fl, busy, done, err;
  logic [1:0] code;
  logic [3:0] ic, oc;

  lpf_frame_ctrl #(
    .LINE_LENGTH (4),
    .LINE_COUNT  (2),
    .FLUSH_CYCLES(2),
    .TIMEOUT     (16)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_start    (start),
    .i_abort    (abort),
    .i_clear    (clear),
    .i_lpf_rd   (lpf_rd),
    .i_obuf_rd  (obuf_rd),
    .i_lpf_error(lpf_err),
    .o_enable   (en),
    .o_flush    (fl),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_err_code (code),
    .o_in_count (ic),
    .o_out_count(oc)
  );

  always #5 clk = ~clk;

  // Input bits: {start, abort, clear, lpf_rd, obuf_rd, lpf_error}
  localparam logic [5:0] I_0 = 6'b000000;
  localparam logic [5:0] I_S = 6'b100000;
  localparam logic [5:0] I_A = 6'b010000;
  localparam logic [5:0] I_C = 6'b001000;
  localparam logic [5:0] I_R = 6'b000100;
  localparam logic [5:0] I_O = 6'b000010;
  localparam logic [5:0] I_E = 6'b000001;

  // Flag bits: {enable, flush, busy, done, err}
  localparam logic [4:0] F_IDLE = 5'b00000;
  localparam logic [4:0] F_RUN  = 5'b10100;
  localparam logic [4:0] F_FLSH = 5'b11100;
  localparam logic [4:0] F_DONE = 5'b00110;
  localparam logic [4:0] F_ABRT = 5'b01100;
  localparam logic [4:0] F_ERR  = 5'b01101;

  typedef struct packed {
    logic [5:0] in;
    logic [4:0] fl;
    logic [1:0] code;
    logic [3:0] ic;
    logic [3:0] oc;
  } vec_t;

  vec_t        tbl[$];
  logic [14:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          norm_n;

  function automatic void add(input logic [5:0] in, input logic [4:0] f,
                              input logic [1:0] c, input int i, input int o);
    vec_t v;
    v.in   = in;
    v.fl   = f;
    v.code = c;
    v.ic   = 4'(i);
    v.oc   = 4'(o);
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int id);
    logic [14:0] got, ex;
    got = {en, fl, busy, done, err, code, ic, oc};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s%0d scoreboard empty, got flags=%b", name, id, got[14:10]);
    end else begin
      ex = exp_q.pop_front();
      if (got !== ex) begin
        errors++;
        $display("FAIL %s%0d got en/fl/busy/done/err=%b code=%b in=%0d out=%0d, want %b code=%b in=%0d out=%0d",
                 name, id, got[14:10], got[9:8], got[7:4], got[3:0],
                 ex[14:10], ex[9:8], ex[7:4], ex[3:0]);
      end
    end
  endtask

  task automatic cyc(input logic [5:0] in, input logic [14:0] ex, input string name, input int id);
    @(negedge clk);
    {start, abort, clear, lpf_rd, obuf_rd, lpf_err} = in;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    check(name, id);
  endtask

  task automatic expect_now(input logic [14:0] ex, input string name, input int id);
    exp_q.push_back(ex);
    check(name, id);
  endtask

  initial begin
    // Normal frame with interleaved output reads
    add(I_S, F_RUN, 2'b00, 0, 0);
    for (int k = 1; k <= 7; k++)
      add((k % 2 == 0) ? (I_R | I_O) : I_R, F_RUN, 2'b00, k, k / 2);
    add(I_R, F_FLSH, 2'b00, 8, 3);
    add(I_O, F_FLSH, 2'b00, 8, 4);
    add(I_O, F_RUN,  2'b00, 8, 5);
    add(I_0, F_RUN,  2'b00, 8, 5);
    add(I_O, F_RUN,  2'b00, 8, 6);
    add(I_O, F_RUN,  2'b00, 8, 7);
    add(I_O, F_DONE, 2'b00, 8, 8);
    add(I_0, F_IDLE, 2'b00, 8, 8);
    add(I_O, F_IDLE, 2'b00, 8, 8);
    norm_n = tbl.size();

    // Early drain, extra output read in FLUSH saturates
    add(I_S, F_RUN, 2'b00, 0, 0);
    for (int k = 1; k <= 7; k++) add(I_R | I_O, F_RUN, 2'b00, k, k);
    add(I_R | I_O, F_FLSH, 2'b00, 8, 8);
    add(I_O, F_FLSH, 2'b00, 8, 8);
    add(I_0, F_RUN,  2'b00, 8, 8);
    add(I_0, F_DONE, 2'b00, 8, 8);
    add(I_0, F_IDLE, 2'b00, 8, 8);

    // Abort after three reads; abort in IDLE is ignored
    add(I_S, F_RUN, 2'b00, 0, 0);
    for (int k = 1; k <= 3; k++) add(I_R, F_RUN, 2'b00, k, 0);
    add(I_A, F_ABRT, 2'b00, 3, 0);
    add(I_0, F_ABRT, 2'b00, 3, 0);
    add(I_0, F_IDLE, 2'b00, 3, 0);
    add(I_A, F_IDLE, 2'b00, 3, 0);

    // Stall: an output read restarts the timer, then 16 quiet cycles trip it
    add(I_S, F_RUN, 2'b00, 0, 0);
    for (int k = 0; k < 10; k++) add(I_0, F_RUN, 2'b00, 0, 0);
    add(I_O, F_RUN, 2'b00, 0, 1);
    for (int k = 0; k < 15; k++) add(I_0, F_RUN, 2'b00, 0, 1);
    add(I_0, F_ERR,  2'b10, 0, 1);
    add(I_R, F_ERR,  2'b10, 0, 1);
    add(I_C, F_IDLE, 2'b10, 0, 1);

    // Overrun: input read during FLUSH
    add(I_S, F_RUN, 2'b10, 0, 0);
    for (int k = 1; k <= 7; k++) add(I_R, F_RUN, 2'b10, k, 0);
    add(I_R, F_FLSH, 2'b10, 8, 0);
    add(I_R, F_ERR,  2'b11, 8, 0);
    add(I_0, F_ERR,  2'b11, 8, 0);
    add(I_C, F_IDLE, 2'b11, 8, 0);

    // Desync beats abort in the same cycle
    add(I_S, F_RUN, 2'b11, 0, 0);
    add(I_R, F_RUN, 2'b11, 1, 0);
    add(I_A | I_E, F_ERR, 2'b01, 1, 0);
    add(I_C, F_IDLE, 2'b01, 1, 0);

    // Start and abort together in IDLE: start wins
    add(I_S | I_A, F_RUN, 2'b01, 0, 0);
    add(I_A, F_ABRT, 2'b01, 0, 0);
    add(I_0, F_ABRT, 2'b01, 0, 0);
    add(I_0, F_IDLE, 2'b01, 0, 0);

    {start, abort, clear, lpf_rd, obuf_rd, lpf_err} = I_0;
    rstn = 1'b0;
    #1;
    expect_now(15'b0, "reset", 0);
    repeat (2) @(posedge clk);
    #1;
    expect_now(15'b0, "reset", 1);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].in, {tbl[i].fl, tbl[i].code, tbl[i].ic, tbl[i].oc}, "vec", i);

    // Reset in the middle of DRAIN
    cyc(I_S, {F_RUN, 2'b01, 4'd0, 4'd0}, "rstdrain", 0);
    for (int k = 1; k <= 7; k++) cyc(I_R, {F_RUN, 2'b01, 4'(k), 4'd0}, "rstdrain", k);
    cyc(I_R, {F_FLSH, 2'b01, 4'd8, 4'd0}, "rstdrain", 8);
    cyc(I_0, {F_FLSH, 2'b01, 4'd8, 4'd0}, "rstdrain", 9);
    cyc(I_0, {F_RUN,  2'b01, 4'd8, 4'd0}, "rstdrain", 10);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    expect_now(15'b0, "rstasync", 0);
    @(posedge clk);
    #1;
    expect_now(15'b0, "rstasync", 1);
    @(negedge clk);
    rstn = 1'b1;

    // Full normal frame after reset
    for (int i = 0; i < norm_n; i++)
      cyc(tbl[i].in, {tbl[i].fl, tbl[i].code, tbl[i].ic, tbl[i].oc}, "again", i);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
